hls_deadlock_report_ctrl: RTL
=============================

Name: hls_deadlock_report_ctrl

Overview:
- Aggregates the per-instance `block` outputs of the HLS deadlock monitors.
- Confirms a deadlock only after the block condition persists for a programmable number of consecutive cycles.
- Snapshots which monitors were blocked and when blocking started, then hands one report to the host/debug side over a valid/ready channel.
- Holds a sticky deadlock flag until software clears it. Sits beside the top-level monitor tree.

Parameters:
- NUM_MON, 4: number of monitor `block` inputs (≥1).
- IDX_W, 2: width of report_idx; must be ≥ clog2(NUM_MON), minimum 1.
- CONFIRM_CYCLES, 16: consecutive blocked samples required to confirm; must be ≥2 and < 2^CNT_W.
- CNT_W, 8: persistence counter width.
- TS_W, 32: timestamp width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  detection enable.
- block_sigs  in  NUM_MON  monitor block outputs, bit i = monitor i.
- clear  in  1  single-cycle pulse; drops sticky state.
- report_valid  out  1  report available.
- report_ready  in  1  consumer accepts report.
- report_idx  out  IDX_W  lowest-index monitor in report_mask.
- report_mask  out  NUM_MON  OR of block_sigs over the confirm window.
- report_ts  out  TS_W  timestamp of the first blocked sample.
- deadlock  out  1  sticky confirmed-deadlock flag.
- busy  out  1  state != IDLE.
- event_count  out  8  saturating count of confirmed deadlocks.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0; persistence counter 0; timestamp counter 0.
  - Reset mid-operation discards any pending report.
- Timestamp counter: free-running TS_W, +1 every cycle, wraps 2^TS_W-1 → 0. The wrap is not flagged.
- blocked = |block_sigs (registered sample, evaluated each rising edge).
- FSM states: IDLE, SUSPECT, REPORT, LATCHED.
- IDLE:
  - enable && blocked → SUSPECT.
  - Set cnt=1, mask=block_sigs, ts=timestamp counter value.
- SUSPECT:
  - !enable or !blocked → IDLE; cnt=0; mask and ts are don't-care and not visible.
  - Else mask |= block_sigs.
  - If cnt == CONFIRM_CYCLES-1 → REPORT; else cnt+=1.
- Confirmation latency:
  - First blocked sample at edge E0, all samples blocked → report_valid and deadlock rise at edge E0+CONFIRM_CYCLES-1.
  - This means exactly CONFIRM_CYCLES consecutive blocked samples.
- On entry to REPORT:
  - report_mask=mask including the final sample; report_ts=ts.
  - report_idx = index of lowest set bit of report_mask.
  - deadlock=1; event_count+=1, saturating at 255.
- REPORT:
  - report_valid=1. report_idx/mask/ts stay stable until the handshake.
  - report_valid && report_ready → LATCHED, report_valid=0 next cycle.
  - enable and block_sigs are ignored.
- LATCHED: deadlock holds 1; report_* hold their values; block_sigs ignored.
- clear has priority in every state:
  - Next state IDLE; deadlock=0; report_valid=0; report_* =0; cnt=0.
  - event_count is unaffected.
  - clear in REPORT aborts the report without a handshake.
  - clear in IDLE is a no-op.
- Simultaneous events:
  - clear with report_ready in REPORT → clear wins, IDLE.
  - clear with blocked in IDLE → IDLE; detection starts next cycle.
- Single report per event: no new detection until clear.
- Blocking that flickers to 0 for even one sample restarts the window.

Test Plan (NUM_MON=4, CONFIRM_CYCLES=4, TS_W=32):
- Reset release, enable=1, block_sigs=0 for 20 cycles → busy=0, deadlock=0, report_valid=0, event_count=0.
- At timestamp 10, block_sigs=4'b0100 held, then 4'b0110 on 4th sample, report_ready=1 → report_valid high 1 cycle at the 4th-sample edge; mask=0110, idx=1, ts=10; deadlock=1; event_count=1; state LATCHED.
- block_sigs=0001 for 3 samples, 0 for 1, then 0001 for 4 → only the second run confirms; report_ts = first cycle of the second run.
- Confirm with report_ready=0 for 5 cycles, toggle block_sigs/enable → valid and payload stable; accepted on ready=1; then LATCHED.
- Pulse clear in LATCHED → next cycle deadlock=0, report_* =0, busy=0; event_count keeps 1; new 4-sample run → event_count=2.
- Assert reset=0 mid-SUSPECT, and again in REPORT with ready=0 → all outputs 0 immediately (async); after release no stale report appears.

Source files
------------

// File: rtl/hls_deadlock_report_ctrl.sv
// Deadlock report controller: confirms a persistent OR of monitor block signals,
// snapshots which monitors blocked and when, and hands one report to the host.
module hls_deadlock_report_ctrl #(
  parameter int NUM_MON        = 4,
  parameter int IDX_W          = 2,
  parameter int CONFIRM_CYCLES = 16,
  parameter int CNT_W          = 8,
  parameter int TS_W           = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_MON-1:0] block_sigs,
  input  logic               clear,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [IDX_W-1:0]   report_idx,
  output logic [NUM_MON-1:0] report_mask,
  output logic [TS_W-1:0]    report_ts,
  output logic               deadlock,
  output logic               busy,
  output logic [7:0]         event_count
);

  typedef enum logic [1:0] {IDLE, SUSPECT, REPORT, LATCHED} state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CONFIRM_CYCLES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_MON-1:0] mask_q;
  logic [TS_W-1:0]    ts_q;
  logic [TS_W-1:0]    ts_cnt_q;
  logic               report_valid_q;
  logic               deadlock_q;
  logic [IDX_W-1:0]   report_idx_q;
  logic [NUM_MON-1:0] report_mask_q;
  logic [TS_W-1:0]    report_ts_q;
  logic [7:0]         event_count_q;

  logic               blocked;
  logic [NUM_MON-1:0] final_mask;

  // Lowest set bit wins: scan downwards so the last hit is the smallest index.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_MON-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (m[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign blocked    = |block_sigs;
  assign final_mask = mask_q | block_sigs;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values and block order cannot change behaviour.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mask_q         <= '0;
      ts_q           <= '0;
      ts_cnt_q       <= '0;
      report_valid_q <= 1'b0;
      deadlock_q     <= 1'b0;
      report_idx_q   <= '0;
      report_mask_q  <= '0;
      report_ts_q    <= '0;
      event_count_q  <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
      if (clear) begin
        state_q        <= IDLE;
        cnt_q          <= '0;
        report_valid_q <= 1'b0;
        deadlock_q     <= 1'b0;
        report_idx_q   <= '0;
        report_mask_q  <= '0;
        report_ts_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (enable && blocked) begin
              state_q <= SUSPECT;
              cnt_q   <= CNT_W'(1);
              mask_q  <= block_sigs;
              ts_q    <= ts_cnt_q;
            end
          end
          SUSPECT: begin
            if (!enable || !blocked) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == LAST_CNT) begin
              state_q        <= REPORT;
              cnt_q          <= '0;
              report_valid_q <= 1'b1;
              deadlock_q     <= 1'b1;
              report_mask_q  <= final_mask;
              report_idx_q   <= lowest_idx(final_mask);
              report_ts_q    <= ts_q;
              if (event_count_q != 8'hFF) event_count_q <= event_count_q + 8'd1;
            end else begin
              cnt_q  <= cnt_q + CNT_W'(1);
              mask_q <= final_mask;
            end
          end
          REPORT: begin
            if (report_ready) begin
              state_q        <= LATCHED;
              report_valid_q <= 1'b0;
            end
          end
          default: ; // LATCHED waits for clear; monitors are ignored
        endcase
      end
    end
  end

  assign report_valid = report_valid_q;
  assign deadlock     = deadlock_q;
  assign report_idx   = report_idx_q;
  assign report_mask  = report_mask_q;
  assign report_ts    = report_ts_q;
  assign event_count  = event_count_q;
  assign busy         = (state_q != IDLE);

endmodule
